// File: rtl/rggen_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rggen_rr_arbiter_if
// Description : Bundle of requester-side and downstream-side signals shared
//               by the round-robin arbiter and its environment.
//               slave  : arbiter view (consumes requests/ready, drives
//                        grant/ack/valid/data).
//               master : environment view (the mirror image).
//   i_request [N]         per-requester request
//   i_data    [WIDTH*N]   per-requester payload, slot i at [WIDTH*i +: WIDTH]
//   o_grant   [N]         registered one-hot grant
//   o_ack     [N]         per-requester completion strobe
//   o_valid               downstream request valid
//   o_data    [WIDTH]     downstream payload
//   i_ready               downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
interface rggen_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 2
);
  logic [N-1:0]       i_request;
  logic [WIDTH*N-1:0] i_data;
  logic [N-1:0]       o_grant;
  logic [N-1:0]       o_ack;
  logic               o_valid;
  logic [WIDTH-1:0]   o_data;
  logic               i_ready;

  modport slave (
    input  i_request,
    input  i_data,
    input  i_ready,
    output o_grant,
    output o_ack,
    output o_valid,
    output o_data
  );

  modport master (
    output i_request,
    output i_data,
    output i_ready,
    input  o_grant,
    input  o_ack,
    input  o_valid,
    input  o_data
  );
endinterface
`default_nettype wire

// File: rtl/rggen_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rggen_rr_arbiter
// Description : Round-robin arbiter sharing one downstream register-access
//               channel between N requesters. Registers a one-hot grant,
//               forwards the granted payload and holds the grant until the
//               downstream handshake (o_valid & i_ready) completes.
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      rggen_rr_arbiter_if.slave (request/data/ready in,
//            grant/ack/valid/data out)
// Revision    : 1.0 - initial release
// ============================================================================
module rggen_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 2
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst_n,
  rggen_rr_arbiter_if.slave   bus
);

  localparam int                     c_PTR_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_PTR_WIDTH-1:0] c_LAST_IDX  = c_PTR_WIDTH'(N - 1);

  typedef enum logic [0:0] {
    c_IDLE = 1'b0,
    c_BUSY = 1'b1
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [N-1:0]           r_grant;
  logic [N-1:0]           w_grant_next;
  logic [c_PTR_WIDTH-1:0] r_ptr;
  logic [c_PTR_WIDTH-1:0] w_ptr_next;

  logic [N-1:0]           w_win_onehot;
  logic [c_PTR_WIDTH-1:0] w_scan_sel;
  logic [c_PTR_WIDTH-1:0] w_grant_idx;
  logic [c_PTR_WIDTH-1:0] w_grant_idx_inc;
  logic [N-1:0]           w_active_grant;
  logic                   w_owner_requesting;
  logic                   w_handshake;

  // AND-OR payload multiplexer selected by a one-hot (or zero) vector;
  // an all-zero select yields zero.
  function automatic logic [WIDTH-1:0] rggen_mux(
    input logic [N-1:0]       sel,
    input logic [WIDTH*N-1:0] data
  );
    logic [WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        result = result | data[WIDTH*i +: WIDTH];
      end
    end
    return result;
  endfunction

  // Scan from the pointer upward with wrap. Iterating from the farthest
  // offset down to zero lets the nearest set request overwrite the others.
  // The wrap is an explicit subtraction so non-power-of-2 N works.
  always_comb begin
    w_win_onehot = '0;
    w_scan_sel   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((int'(r_ptr) + k) >= N) begin
        w_scan_sel = c_PTR_WIDTH'(int'(r_ptr) + k - N);
      end else begin
        w_scan_sel = c_PTR_WIDTH'(int'(r_ptr) + k);
      end
      if (bus.i_request[w_scan_sel]) begin
        w_win_onehot             = '0;
        w_win_onehot[w_scan_sel] = 1'b1;
      end
    end
  end

  // Index of the current owner, and the pointer it hands on to.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_grant_idx = c_PTR_WIDTH'(i);
      end
    end
    w_grant_idx_inc = (w_grant_idx == c_LAST_IDX) ? '0 : (w_grant_idx + 1'b1);
  end

  // While reset is asserted the registered grant may still be set for the
  // cycle before the reset edge; masking it keeps valid/ack/data quiet so a
  // reset never produces an ack.
  assign w_active_grant     = r_grant & {N{i_rst_n}};
  assign w_owner_requesting = |(w_active_grant & bus.i_request);
  assign w_handshake        = w_owner_requesting & bus.i_ready;

  assign bus.o_grant = r_grant;
  assign bus.o_valid = w_owner_requesting;
  assign bus.o_ack   = w_active_grant & {N{w_handshake}};
  assign bus.o_data  = rggen_mux(w_active_grant, bus.i_data);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      c_IDLE: begin
        if (|bus.i_request) begin
          w_state_next = c_BUSY;
          w_grant_next = w_win_onehot;
        end
      end
      c_BUSY: begin
        if (w_handshake) begin
          w_state_next = c_IDLE;
          w_grant_next = '0;
          w_ptr_next   = w_grant_idx_inc;
        end else if (!w_owner_requesting) begin
          // Owner withdrew: release without moving the pointer.
          w_state_next = c_IDLE;
          w_grant_next = '0;
        end
      end
      default: begin
        w_state_next = c_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rggen_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rggen_rr_arbiter
// Description : Self-checking bench for rggen_rr_arbiter (N=4, WIDTH=8).
//               Directed scenarios with literal expectations, plus a
//               transaction-level model of ownership compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rggen_rr_arbiter;

  localparam int c_N     = 4;
  localparam int c_WIDTH = 8;
  localparam logic [31:0] c_DATA = 32'h44332211;

  logic clk;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: which requester owns the channel (-1 = nobody) and who has
  // highest priority next.
  int   m_owner   = -1;
  int   m_ptr     = 0;
  logic m_started = 1'b0;

  rggen_rr_arbiter_if #(.WIDTH(c_WIDTH), .N(c_N)) bus ();

  rggen_rr_arbiter #(.WIDTH(c_WIDTH), .N(c_N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership rules, evaluated on each rising edge with the inputs that
  // were present during the cycle that is ending.
  always @(posedge clk) begin
    int own;
    int ptr;
    own = m_owner;
    ptr = m_ptr;
    if (!rst_n) begin
      own = -1;
      ptr = 0;
    end else if (own < 0) begin
      for (int k = 0; k < c_N; k++) begin
        if (own < 0 && bus.i_request[(m_ptr + k) % c_N]) own = (m_ptr + k) % c_N;
      end
    end else if (!bus.i_request[own]) begin
      own = -1;
    end else if (bus.i_ready) begin
      ptr = (own + 1) % c_N;
      own = -1;
    end
    m_owner   <= own;
    m_ptr     <= ptr;
    m_started <= 1'b1;
  end

  // Per-cycle comparison, mid-cycle so inputs and outputs are settled.
  always @(negedge clk) begin
    logic [3:0] eg;
    logic [3:0] ea;
    logic       ev;
    logic [7:0] ed;
    eg = 4'b0;
    ea = 4'b0;
    ev = 1'b0;
    ed = 8'h00;
    if (m_started) begin
      if (m_owner >= 0) begin
        eg = 4'b0001 << m_owner;
        if (rst_n) begin
          ed = bus.i_data[m_owner*c_WIDTH +: c_WIDTH];
          ev = bus.i_request[m_owner];
        end
      end
      if (ev && bus.i_ready) ea = eg;
      check("model_grant", 32'(bus.o_grant), 32'(eg));
      check("model_valid", 32'(bus.o_valid), 32'(ev));
      check("model_ack",   32'(bus.o_ack),   32'(ea));
      check("model_data",  32'(bus.o_data),  32'(ed));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  localparam logic [3:0] c_RR_SEQ [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                          4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst_n         = 1'b0;
    bus.i_request = 4'b1111;
    bus.i_ready   = 1'b0;
    bus.i_data    = c_DATA;

    // Reset held with all requests up.
    for (int i = 0; i < 3; i++) begin
      smp();
      check("rst_grant", 32'(bus.o_grant), 32'h0);
      check("rst_valid", 32'(bus.o_valid), 32'h0);
      check("rst_ack",   32'(bus.o_ack),   32'h0);
    end
    cyc(); rst_n = 1'b1;
    smp(); check("rel_idle", 32'(bus.o_grant), 32'h0);
    smp(); check("rel_first_grant", 32'(bus.o_grant), 32'b0001);
    cyc(); bus.i_request = 4'b0000;
    smp(); smp(); check("rel_withdraw_idle", 32'(bus.o_grant), 32'h0);

    // Single request, ready already high (ignored while idle).
    cyc(); bus.i_request = 4'b0100; bus.i_data = 32'h44A52211; bus.i_ready = 1'b1;
    smp(); check("single_idle_ack", 32'(bus.o_ack), 32'h0);
    smp();
    check("single_grant", 32'(bus.o_grant), 32'b0100);
    check("single_data",  32'(bus.o_data),  32'hA5);
    check("single_ack",   32'(bus.o_ack),   32'b0100);
    cyc(); bus.i_request = 4'b0000;
    smp(); check("single_after", 32'(bus.o_grant), 32'h0);

    // Reset pulse to bring the pointer back to 0, then full contention.
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; bus.i_request = 4'b1111; bus.i_ready = 1'b1; bus.i_data = c_DATA;
    smp(); check("rr_start_idle", 32'(bus.o_grant), 32'h0);
    for (int i = 0; i < 9; i++) begin
      smp();
      check("rr_seq", 32'(bus.o_grant), 32'(c_RR_SEQ[i]));
    end
    cyc(); bus.i_request = 4'b0000; bus.i_ready = 1'b0;
    smp();

    // Backpressure on requester 0; requester 3 arrives meanwhile.
    cyc(); bus.i_request = 4'b0001; bus.i_data = 32'h4433223C;
    smp();
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 1) bus.i_request = 4'b1001;
      smp();
      check("bp_grant", 32'(bus.o_grant), 32'b0001);
      check("bp_data",  32'(bus.o_data),  32'h3C);
      check("bp_ack",   32'(bus.o_ack),   32'h0);
    end
    cyc(); bus.i_ready = 1'b1;
    smp(); check("bp_ack_release", 32'(bus.o_ack), 32'b0001);
    cyc(); bus.i_request = 4'b1000;
    smp(); check("bp_bubble", 32'(bus.o_grant), 32'h0);
    smp(); check("bp_next_grant", 32'(bus.o_grant), 32'b1000);
    cyc(); bus.i_request = 4'b0000; bus.i_ready = 1'b0;
    smp();

    // One transfer by requester 0 moves the pointer to 1.
    cyc(); bus.i_request = 4'b0001; bus.i_ready = 1'b1;
    smp();
    smp(); check("pre_wd_ack", 32'(bus.o_ack), 32'b0001);
    cyc(); bus.i_request = 4'b0000; bus.i_ready = 1'b0;
    smp();

    // Withdrawal by requester 1, with ready rising in the same cycle.
    cyc(); bus.i_request = 4'b0010;
    smp();
    smp(); check("wd_grant", 32'(bus.o_grant), 32'b0010);
    cyc(); bus.i_request = 4'b0000; bus.i_ready = 1'b1;
    smp();
    check("wd_valid", 32'(bus.o_valid), 32'h0);
    check("wd_ack",   32'(bus.o_ack),   32'h0);
    cyc(); bus.i_request = 4'b0011; bus.i_ready = 1'b0;
    smp(); check("wd_idle", 32'(bus.o_grant), 32'h0);
    smp(); check("wd_ptr_kept", 32'(bus.o_grant), 32'b0010);
    cyc(); bus.i_ready = 1'b1;
    smp(); check("wd_regrant_ack", 32'(bus.o_ack), 32'b0010);
    cyc(); bus.i_request = 4'b1000; bus.i_ready = 1'b0;
    smp();
    smp(); check("mr_grant", 32'(bus.o_grant), 32'b1000);

    // Reset while busy: no ack even with ready high, grant drops.
    cyc(); rst_n = 1'b0; bus.i_ready = 1'b1;
    smp();
    check("mr_ack",   32'(bus.o_ack),   32'h0);
    check("mr_valid", 32'(bus.o_valid), 32'h0);
    cyc(); rst_n = 1'b1; bus.i_request = 4'b1111; bus.i_ready = 1'b0;
    smp(); check("mr_dropped", 32'(bus.o_grant), 32'h0);
    smp(); check("mr_first_grant", 32'(bus.o_grant), 32'b0001);
    cyc(); bus.i_request = 4'b0000;
    repeat (3) smp();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
